// File: rtl/fight_referee.sv
// fight_referee: match controller for the two-player fighting datapath.
//
// Generates the game tick, turns raw controller codes into one-shot
// per-tick action codes, resets both players at round start, detects KO or
// timeout and runs a best-of-N match.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a match (honoured in IDLE / MATCH_OVER only)
//   left/right_raw_input  raw 6-bit action codes from the controllers
//   left/right_health     2-bit player health fed back from the players
//   left/right_player_input  gated one-shot action codes to the players
//   player_rst_n          registered active-low reset to both players
//   state                 FSM state (IDLE 0 .. MATCH_OVER 5)
//   round_timer           fight ticks remaining in the round
//   left/right_wins       rounds won so far (saturating at 3)
//   round_winner          00 none, 01 left, 10 right, 11 draw
//   match_winner          same encoding, 00 while the match runs
//
// Action issue timing: latched actions are presented on
// left/right_player_input for exactly one cycle, the cycle after a FIGHT
// tick that does not end the round; every other cycle they read 000000.
// There is no back-pressure: the players must consume the code that cycle.
module fight_referee #(
  parameter int TICK_CYCLES     = 4,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int ROUND_TICKS     = 30,
  parameter int WINS_NEEDED     = 2,
  parameter int MAX_ROUNDS      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] left_raw_input,
  input  logic [5:0] right_raw_input,
  input  logic [1:0] left_health,
  input  logic [1:0] right_health,
  output logic [5:0] left_player_input,
  output logic [5:0] right_player_input,
  output logic       player_rst_n,
  output logic [2:0] state,
  output logic [4:0] round_timer,
  output logic [1:0] left_wins,
  output logic [1:0] right_wins,
  output logic [1:0] round_winner,
  output logic [1:0] match_winner
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int PW = $clog2(COUNTDOWN_TICKS + 1);
  localparam int RW = $clog2(MAX_ROUNDS + 1);

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_LAST  = PW'(COUNTDOWN_TICKS - 1);
  localparam logic [RW-1:0] ROUNDS_MAX  = RW'(MAX_ROUNDS);
  localparam logic [4:0]    TIMER_START = 5'(ROUND_TICKS);
  localparam logic [1:0]    WINS_TARGET = 2'(WINS_NEEDED);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ROUND_INIT = 3'd1,
    S_COUNTDOWN  = 3'd2,
    S_FIGHT      = 3'd3,
    S_ROUND_END  = 3'd4,
    S_MATCH_OVER = 3'd5
  } state_t;

  state_t        state_q;
  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] phase_cnt;
  logic [RW-1:0] round_cnt;
  logic [5:0]    left_latch;
  logic [5:0]    right_latch;

  logic          counting;
  logic          tick;
  logic [5:0]    left_legal;
  logic [5:0]    right_legal;
  logic [5:0]    left_next;
  logic [5:0]    right_next;
  logic          round_over;
  logic [1:0]    outcome;
  logic          match_done;
  logic [1:0]    match_result;

  assign state = state_q;

  // The tick counter only runs in the three timed states; holding it at 0
  // elsewhere and wrapping on every tick means it is 0 on entry to each.
  assign counting = (state_q == S_COUNTDOWN) || (state_q == S_FIGHT) ||
                    (state_q == S_ROUND_END);
  assign tick     = counting && (tick_cnt == TICK_LAST);

  // Legal codes are exactly the one-hot ones; anything else is a no-op.
  assign left_legal  = $onehot(left_raw_input)  ? left_raw_input  : 6'b000000;
  assign right_legal = $onehot(right_raw_input) ? right_raw_input : 6'b000000;

  // A fresh legal code arriving on the tick cycle still makes this issue.
  assign left_next  = (left_legal  != 6'b000000) ? left_legal  : left_latch;
  assign right_next = (right_legal != 6'b000000) ? right_legal : right_latch;

  // Round outcome, priority: double KO, single KO, timeout.
  always_comb begin
    round_over = 1'b0;
    outcome    = 2'b00;
    if (left_health == 2'd0 && right_health == 2'd0) begin
      round_over = 1'b1;
      outcome    = 2'b11;
    end else if (left_health == 2'd0) begin
      round_over = 1'b1;
      outcome    = 2'b10;
    end else if (right_health == 2'd0) begin
      round_over = 1'b1;
      outcome    = 2'b01;
    end else if (round_timer == 5'd0) begin
      round_over = 1'b1;
      if (left_health > right_health)      outcome = 2'b01;
      else if (right_health > left_health) outcome = 2'b10;
      else                                 outcome = 2'b11;
    end
  end

  // Match decision taken at the end of ROUND_END, using the updated wins.
  always_comb begin
    match_done   = 1'b0;
    match_result = 2'b00;
    if (left_wins == WINS_TARGET) begin
      match_done   = 1'b1;
      match_result = 2'b01;
    end else if (right_wins == WINS_TARGET) begin
      match_done   = 1'b1;
      match_result = 2'b10;
    end else if (round_cnt == ROUNDS_MAX) begin
      match_done = 1'b1;
      if (left_wins > right_wins)      match_result = 2'b01;
      else if (right_wins > left_wins) match_result = 2'b10;
      else                             match_result = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= S_IDLE;
      tick_cnt           <= '0;
      phase_cnt          <= '0;
      round_cnt          <= '0;
      left_latch         <= 6'b000000;
      right_latch        <= 6'b000000;
      left_player_input  <= 6'b000000;
      right_player_input <= 6'b000000;
      player_rst_n       <= 1'b0;
      round_timer        <= 5'd0;
      left_wins          <= 2'd0;
      right_wins         <= 2'd0;
      round_winner       <= 2'b00;
      match_winner       <= 2'b00;
    end else begin
      // Issued actions last one cycle only.
      left_player_input  <= 6'b000000;
      right_player_input <= 6'b000000;

      if (!counting)  tick_cnt <= '0;
      else if (tick)  tick_cnt <= '0;
      else            tick_cnt <= tick_cnt + 1'b1;

      case (state_q)
        S_IDLE, S_MATCH_OVER: begin
          if (state_q == S_IDLE) player_rst_n <= 1'b1;
          if (start) begin
            left_wins    <= 2'd0;
            right_wins   <= 2'd0;
            match_winner <= 2'b00;
            round_cnt    <= RW'(1);
            // Round-init values are set on entry so they are visible
            // during the single ROUND_INIT cycle.
            player_rst_n <= 1'b0;
            round_timer  <= TIMER_START;
            round_winner <= 2'b00;
            state_q      <= S_ROUND_INIT;
          end
        end

        S_ROUND_INIT: begin
          player_rst_n <= 1'b1;
          phase_cnt    <= '0;
          state_q      <= S_COUNTDOWN;
        end

        S_COUNTDOWN: begin
          left_latch  <= 6'b000000;
          right_latch <= 6'b000000;
          if (tick) begin
            if (phase_cnt == PHASE_LAST) begin
              phase_cnt <= '0;
              state_q   <= S_FIGHT;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
        end

        S_FIGHT: begin
          left_latch  <= left_next;
          right_latch <= right_next;
          if (tick) begin
            left_latch  <= 6'b000000;
            right_latch <= 6'b000000;
            if (round_over) begin
              round_winner <= outcome;
              if (outcome == 2'b01 && left_wins != 2'd3)
                left_wins <= left_wins + 2'd1;
              if (outcome == 2'b10 && right_wins != 2'd3)
                right_wins <= right_wins + 2'd1;
              phase_cnt <= '0;
              state_q   <= S_ROUND_END;
            end else begin
              left_player_input  <= left_next;
              right_player_input <= right_next;
              round_timer        <= round_timer - 5'd1;
            end
          end
        end

        S_ROUND_END: begin
          if (tick) begin
            if (phase_cnt == PHASE_LAST) begin
              phase_cnt <= '0;
              if (match_done) begin
                match_winner <= match_result;
                state_q      <= S_MATCH_OVER;
              end else begin
                round_cnt    <= round_cnt + 1'b1;
                player_rst_n <= 1'b0;
                round_timer  <= TIMER_START;
                round_winner <= 2'b00;
                state_q      <= S_ROUND_INIT;
              end
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fight_referee.sv
// tb_fight_referee: directed bench for fight_referee.
// Expected observations (state changes and issued actions) are queued by the
// stimulus; a negedge monitor pops and compares each one as the DUT shows it.
module tb_fight_referee;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] left_raw_input;
  logic [5:0] right_raw_input;
  logic [1:0] left_health;
  logic [1:0] right_health;
  logic [5:0] left_player_input;
  logic [5:0] right_player_input;
  logic       player_rst_n;
  logic [2:0] state;
  logic [4:0] round_timer;
  logic [1:0] left_wins;
  logic [1:0] right_wins;
  logic [1:0] round_winner;
  logic [1:0] match_winner;

  int tests = 0;
  int fails = 0;

  logic [28:0] exp_q[$];
  logic [28:0] obs;
  logic [28:0] exp_obs;
  logic [2:0]  prev_state = 3'd0;

  fight_referee dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .left_raw_input     (left_raw_input),
    .right_raw_input    (right_raw_input),
    .left_health        (left_health),
    .right_health       (right_health),
    .left_player_input  (left_player_input),
    .right_player_input (right_player_input),
    .player_rst_n       (player_rst_n),
    .state              (state),
    .round_timer        (round_timer),
    .left_wins          (left_wins),
    .right_wins         (right_wins),
    .round_winner       (round_winner),
    .match_winner       (match_winner)
  );

  // Clock
  always #5 clk = ~clk;

  assign obs = {state, player_rst_n, round_timer, left_wins, right_wins,
                round_winner, match_winner, left_player_input,
                right_player_input};

  function automatic logic [28:0] mk(input logic [2:0] st, input logic prn,
                                     input logic [4:0] tmr,
                                     input logic [1:0] lw, input logic [1:0] rw,
                                     input logic [1:0] rwin,
                                     input logic [1:0] mwin,
                                     input logic [5:0] lpi,
                                     input logic [5:0] rpi);
    return {st, prn, tmr, lw, rw, rwin, mwin, lpi, rpi};
  endfunction

  // Scoreboard monitor: an event is a state change or a nonzero issue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_state = 3'd0;
    end else begin
      if (state != prev_state || left_player_input != 6'd0 ||
          right_player_input != 6'd0) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event got=%h required=none (t=%0t)",
                   obs, $time);
        end else begin
          exp_obs = exp_q.pop_front();
          if (obs !== exp_obs) begin
            fails++;
            $display("FAIL event got=%h required=%h (t=%0t)",
                     obs, exp_obs, $time);
          end
        end
      end
      prev_state = state;
    end
  end

  // Driver / checker tasks
  task automatic check(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit,
                            output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state != s && n < limit);
    tests++;
    if (state != s) begin
      fails++;
      $display("FAIL wait_state_%0d got=%0d required=%0d", s, state, s);
    end
  endtask

  task automatic push_round_start(input logic [1:0] lw, input logic [1:0] rw);
    exp_q.push_back(mk(3'd1, 1'b0, 5'd30, lw, rw, 2'b00, 2'b00, 6'd0, 6'd0));
    exp_q.push_back(mk(3'd2, 1'b1, 5'd30, lw, rw, 2'b00, 2'b00, 6'd0, 6'd0));
    exp_q.push_back(mk(3'd3, 1'b1, 5'd30, lw, rw, 2'b00, 2'b00, 6'd0, 6'd0));
  endtask

  int n;

  initial begin
    // Reset
    rst_n           = 1'b0;
    start           = 1'b0;
    left_raw_input  = 6'd0;
    right_raw_input = 6'd0;
    left_health     = 2'd3;
    right_health    = 2'd3;
    repeat (2) @(negedge clk);
    check("reset_state", state, 0);
    check("reset_prn", player_rst_n, 0);
    check("reset_outputs", {left_player_input, right_player_input, round_timer,
                            left_wins, right_wins, round_winner, match_winner}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("prn_release", player_rst_n, 1);
    check("idle_state", state, 0);

    // Round 1: start, action issue, illegal code, KO by left
    start = 1'b1;
    push_round_start(2'd0, 2'd0);
    @(negedge clk);
    start = 1'b0;
    wait_state(3'd2, 50, n);
    check("round_init_len", n, 1);
    wait_state(3'd3, 50, n);
    check("countdown_len", n, 12);
    @(negedge clk);
    left_raw_input = 6'b000001;
    exp_q.push_back(mk(3'd3, 1'b1, 5'd29, 2'd0, 2'd0, 2'b00, 2'b00,
                       6'b000001, 6'b000000));
    @(negedge clk);
    left_raw_input = 6'd0;
    repeat (3) @(negedge clk);
    left_raw_input  = 6'b000011;
    right_raw_input = 6'b100000;
    exp_q.push_back(mk(3'd3, 1'b1, 5'd28, 2'd0, 2'd0, 2'b00, 2'b00,
                       6'b000000, 6'b100000));
    @(negedge clk);
    left_raw_input  = 6'd0;
    right_raw_input = 6'd0;
    repeat (3) @(negedge clk);
    right_health = 2'd0;
    exp_q.push_back(mk(3'd4, 1'b1, 5'd28, 2'd1, 2'd0, 2'b01, 2'b00, 6'd0, 6'd0));
    wait_state(3'd4, 50, n);
    check("ko_latency", n, 3);
    right_health = 2'd3;
    push_round_start(2'd1, 2'd0);
    wait_state(3'd1, 50, n);
    check("round_end_len", n, 12);

    // Round 2: timeout with equal health -> draw
    wait_state(3'd3, 50, n);
    exp_q.push_back(mk(3'd4, 1'b1, 5'd0, 2'd1, 2'd0, 2'b11, 2'b00, 6'd0, 6'd0));
    wait_state(3'd4, 300, n);
    check("timeout_len", n, 124);

    // Round 3: timeout, left weaker -> right wins; start is ignored mid-fight
    left_health = 2'd2;
    push_round_start(2'd1, 2'd0);
    exp_q.push_back(mk(3'd4, 1'b1, 5'd0, 2'd1, 2'd1, 2'b10, 2'b00, 6'd0, 6'd0));
    wait_state(3'd3, 50, n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state(3'd4, 300, n);

    // Round 4: left KO win -> match over, left takes the match
    left_health  = 2'd3;
    right_health = 2'd0;
    push_round_start(2'd1, 2'd1);
    exp_q.push_back(mk(3'd4, 1'b1, 5'd30, 2'd2, 2'd1, 2'b01, 2'b00, 6'd0, 6'd0));
    exp_q.push_back(mk(3'd5, 1'b1, 5'd30, 2'd2, 2'd1, 2'b01, 2'b01, 6'd0, 6'd0));
    wait_state(3'd5, 400, n);
    repeat (20) @(negedge clk);
    check("match_over_hold", state, 5);
    check("match_winner_left", match_winner, 1);

    // New match: five draws -> match over with 11
    right_health = 2'd3;
    start = 1'b1;
    push_round_start(2'd0, 2'd0);
    @(negedge clk);
    start = 1'b0;
    check("wins_cleared", {left_wins, right_wins}, 0);
    check("match_winner_cleared", match_winner, 0);
    for (int r = 1; r <= 5; r++) begin
      exp_q.push_back(mk(3'd4, 1'b1, 5'd0, 2'd0, 2'd0, 2'b11, 2'b00, 6'd0, 6'd0));
      if (r < 5) push_round_start(2'd0, 2'd0);
      else exp_q.push_back(mk(3'd5, 1'b1, 5'd0, 2'd0, 2'd0, 2'b11, 2'b11,
                              6'd0, 6'd0));
    end
    wait_state(3'd5, 1000, n);
    check("match_winner_draw", match_winner, 3);

    // Reset mid-fight aborts immediately
    start = 1'b1;
    push_round_start(2'd0, 2'd0);
    @(negedge clk);
    start = 1'b0;
    wait_state(3'd3, 50, n);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_state", state, 0);
    check("abort_outputs", {left_player_input, right_player_input, player_rst_n,
                            round_timer, left_wins, right_wins, round_winner,
                            match_winner}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_abort_idle", state, 0);
    check("queue_drained", exp_q.size(), 0);

    // Report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fight_referee.md
Name: fight_referee

Overview:
- Match controller for the two-player fighting datapath (left/right player blocks).
- Generates the game tick, filters raw controller actions into one-shot per-tick action codes, resets both players at round start, and detects KO or timeout.
- Runs a best-of-N match and reports round and match winners to the display/top level.

Parameters:
TICK_CYCLES, 4, clk cycles per game tick; must be >= 4 so player health settles before the next evaluation.
COUNTDOWN_TICKS, 3, ticks spent in COUNTDOWN and in ROUND_END.
ROUND_TICKS, 30, fight ticks per round before timeout; must be <= 31.
WINS_NEEDED, 2, round wins that end the match.
MAX_ROUNDS, 5, hard cap on rounds per match.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a match; honoured only in IDLE or MATCH_OVER
left_raw_input  in  6  raw action code, left controller
right_raw_input  in  6  raw action code, right controller
left_health  in  2  left player health
right_health  in  2  right player health
left_player_input  out  6  gated action code to the players
right_player_input  out  6  gated action code to the players
player_rst_n  out  1  registered active-low reset to both players
state  out  3  FSM state
round_timer  out  5  fight ticks remaining
left_wins  out  2  rounds won by left
right_wins  out  2  rounds won by right
round_winner  out  2  00 none, 01 left, 10 right, 11 draw
match_winner  out  2  same encoding as round_winner; 00 while the match is running

Behaviour:
- Reset, asynchronous: state = IDLE; all outputs 0, including player_rst_n = 0. player_rst_n rises on the first clk after release. Reset mid-round aborts everything; no state is retained.
- Legal action codes: 100000 right, 010000 left, 001000 wait, 000100 jump, 000010 kick, 000001 punch. Any other nonzero code is illegal and is treated as 000000. 000000 is a no-op for the players.
- Tick counter: runs only in COUNTDOWN, FIGHT and ROUND_END; it is cleared on entry to each. The tick pulse is asserted when the count = TICK_CYCLES-1, then the counter wraps to 0.
- Action latch, per player, in FIGHT: a legal nonzero raw input overwrites the latch. The latch is cleared on the cycle after issue.
- Issue: on the cycle after a FIGHT tick, if the round continues, left/right_player_input = latch contents for exactly 1 cycle; otherwise they are 000000. Outputs are registered, so latency from raw input to issue is 1 to TICK_CYCLES+1 cycles.
- State encoding: IDLE 0, ROUND_INIT 1, COUNTDOWN 2, FIGHT 3, ROUND_END 4, MATCH_OVER 5.
- IDLE: on start, go to ROUND_INIT, clear wins and the round count, and set match_winner = 00.
- ROUND_INIT (1 cycle): player_rst_n = 0, round_timer = ROUND_TICKS, round_winner = 00, round count +1; then go to COUNTDOWN.
- COUNTDOWN: after COUNTDOWN_TICKS ticks, go to FIGHT. Actions are blocked and latches are held clear.
- FIGHT, evaluated on each tick in this priority order:
  - Both health values = 0: draw.
  - Exactly one health value = 0: the other player wins.
  - round_timer = 0: the higher health wins; equal health is a draw.
  - Otherwise: issue actions and decrement round_timer.
- Round end: the outcome is latched into round_winner; the winner's win count increments, saturating at 3; a draw increments neither. Then go to ROUND_END.
- ROUND_END: after COUNTDOWN_TICKS ticks, evaluate:
  - Either wins = WINS_NEEDED: go to MATCH_OVER with that player as match_winner.
  - Otherwise, round count = MAX_ROUNDS: go to MATCH_OVER; the higher win count wins, equal counts give 11.
  - Otherwise: go to ROUND_INIT.
- MATCH_OVER: all outputs hold. start goes to ROUND_INIT with wins and round count cleared and match_winner = 00.
- start is ignored in every other state.

Test Plan:
- Reset, start pulse → ROUND_INIT for 1 cycle with player_rst_n = 0 → COUNTDOWN for 12 cycles → FIGHT with round_timer = 30.
- In FIGHT, left_raw = 000001 for 1 cycle mid-tick-window → left_player_input = 000001 for exactly 1 cycle after the tick, then 000000. Raw 000011 → 000000 is issued.
- Force right_health = 0 → at the next tick round_winner = 01, left_wins = 1, state = ROUND_END, outputs 000000.
- Both health 3, no KO for 30 ticks → timeout draw (11) with wins unchanged. Repeat with left health 2 → right wins the round.
- Left wins two rounds → match_winner = 01, state 5 holds. start → wins cleared and a new round begins.
- Five consecutive draws → MATCH_OVER after round 5 with match_winner = 11. Assert rst_n low mid-FIGHT → IDLE immediately with all outputs 0.
